magic_cfg_loader: RTL and testbench

Power-up settings loader for the magic configuration register set. SPI mode-0 master that reads a signed settings image from a 25-series serial EEPROM. It replays each stored byte as a config-register write, which drives the same register map the CPU programs through I/O port xxFF (index 0x00..0x09). Sits beside the magic config block and muxes its write strobes with CPU writes; holds the machine idle via busy until the image is applied.

---
 rtl/magic_cfg_loader_if.sv | 33 +++
 rtl/magic_cfg_loader.sv | 218 +++++++++++++++++++++
 tb/tb_magic_cfg_loader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/magic_cfg_loader_if.sv
// +----------------------------------------------------------------------------+
// | magic_cfg_loader_if                                                          |
// | SPI EEPROM pins, config-register write bus and loader status.               |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface magic_cfg_loader_if;
  logic       start;
  logic       spi_miso;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       cfg_wr;
  logic [7:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       busy;
  logic       done;
  logic       valid;

  modport master (
    input  start, spi_miso,
    output spi_sck, spi_cs_n, spi_mosi, cfg_wr, cfg_addr, cfg_data, busy, done, valid
  );

  modport slave (
    output start, spi_miso,
    input  spi_sck, spi_cs_n, spi_mosi, cfg_wr, cfg_addr, cfg_data, busy, done, valid
  );
endinterface

`default_nettype wire

// File: rtl/magic_cfg_loader.sv
// +----------------------------------------------------------------------------+
// | magic_cfg_loader                                                             |
// | Reads a signed settings image from a 25-series SPI EEPROM (mode 0) and       |
// | replays each byte as a config-register write.                                |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module magic_cfg_loader #(
  parameter int          NUM_REGS  = 10,
  parameter logic [7:0]  SIGNATURE = 8'h5A,
  parameter logic [15:0] EE_ADDR   = 16'h0000,
  parameter int          SCK_DIV   = 4
) (
  input  logic              clk28,
  input  logic              rst,
  magic_cfg_loader_if.master bus
);

  localparam int               CNT_W    = $clog2(2 * SCK_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(2 * SCK_DIV - 1);
  localparam logic [7:0]       LAST_IDX = 8'(NUM_REGS - 1);
  localparam logic [23:0]      CMD_WORD = {8'h03, EE_ADDR};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    CMD      = 3'd2,
    SIG      = 3'd3,
    DATA     = 3'd4,
    CS_HOLD  = 3'd5,
    GAP      = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic [7:0]       byte_q, byte_d;
  logic [7:0]       rx_q, rx_d;
  logic [23:0]      cmd_q, cmd_d;
  logic             auto_q, auto_d;
  logic             sck_q, sck_d;
  logic             cs_n_q, cs_n_d;
  logic             wr_q, wr_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic             half_done;

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      rx_q    <= '0;
      cmd_q   <= '0;
      auto_q  <= 1'b1;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      rx_q    <= rx_d;
      cmd_q   <= cmd_d;
      auto_q  <= auto_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    rx_d      = rx_q;
    cmd_d     = cmd_q;
    auto_d    = auto_q;
    sck_d     = sck_q;
    cs_n_d    = cs_n_q;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = done_q;
    valid_d   = valid_q;
    half_done = (div_q == DIV_LAST);

    case (state_q)
      IDLE: begin
        if (bus.start || auto_q) begin
          auto_d  = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          valid_d = 1'b0;
          cs_n_d  = 1'b0;
          cmd_d   = CMD_WORD;
          div_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
          state_d = CS_SETUP;
        end
      end

      CS_SETUP: begin
        if (half_done) begin
          div_d   = '0;
          state_d = CMD;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      CMD, SIG, DATA: begin
        if (!half_done) begin
          div_d = div_q + 1'b1;
        end else if (!sck_q) begin
          // Rising SCK: MISO is captured on this same clock.
          div_d = '0;
          sck_d = 1'b1;
          rx_d  = {rx_q[6:0], bus.spi_miso};
          if (state_q == DATA && bit_q == 5'd7) begin
            wr_d   = 1'b1;
            addr_d = byte_q;
            data_d = {rx_q[6:0], bus.spi_miso};
          end
        end else begin
          // Falling SCK: bit complete, MOSI advances into the next low phase.
          div_d = '0;
          sck_d = 1'b0;
          bit_d = bit_q + 5'd1;
          case (state_q)
            CMD: begin
              cmd_d = {cmd_q[22:0], 1'b0};
              if (bit_q == 5'd23) begin
                bit_d   = '0;
                state_d = SIG;
              end
            end
            SIG: begin
              if (bit_q == 5'd7) begin
                bit_d   = '0;
                state_d = (rx_q == SIGNATURE) ? DATA : CS_HOLD;
              end
            end
            default: begin
              if (bit_q == 5'd7) begin
                bit_d = '0;
                if (byte_q == LAST_IDX) begin
                  valid_d = 1'b1;
                  state_d = CS_HOLD;
                end else begin
                  byte_d = byte_q + 8'd1;
                end
              end
            end
          endcase
        end
      end

      CS_HOLD: begin
        if (half_done) begin
          div_d   = '0;
          cs_n_d  = 1'b1;
          state_d = GAP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      GAP: begin
        if (div_q == GAP_LAST) begin
          div_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // The command shifter empties to zero, which leaves MOSI low after CMD.
  assign bus.spi_mosi = cmd_q[23];
  assign bus.spi_sck  = sck_q;
  assign bus.spi_cs_n = cs_n_q;
  assign bus.cfg_wr   = wr_q;
  assign bus.cfg_addr = addr_q;
  assign bus.cfg_data = data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.valid    = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_magic_cfg_loader.sv
// +----------------------------------------------------------------------------+
// | tb_magic_cfg_loader                                                          |
// | Two loaders (10 regs @0x0000, 1 reg @0x0100) against a 25-series EEPROM     |
// | model; write sequences are predicted from the EEPROM contents.               |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_magic_cfg_loader;
  localparam int SCK_DIV = 4;
  localparam int PER     = 10;

  logic clk28 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk28 = ~clk28;

  magic_cfg_loader_if bus0 ();
  magic_cfg_loader_if bus1 ();

  logic [7:0] mem [0:1][0:511];
  int ncmp = 0;
  int nerr = 0;

  magic_cfg_loader #(.NUM_REGS(10), .SIGNATURE(8'h5A), .EE_ADDR(16'h0000), .SCK_DIV(SCK_DIV))
    dut0 (.clk28(clk28), .rst(rst), .bus(bus0));
  magic_cfg_loader #(.NUM_REGS(1), .SIGNATURE(8'h5A), .EE_ADDR(16'h0100), .SCK_DIV(SCK_DIV))
    dut1 (.clk28(clk28), .rst(rst), .bus(bus1));

  // EEPROM model plus bus monitors, one per loader.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic sck, cs_n, mosi, wr;
    logic [7:0] wa, wd;
    logic miso = 1'b0;
    logic mosi_rise = 1'b0;
    logic [23:0] cmdcap = '0;
    logic [15:0] wlog [0:63];
    logic [8:0] a;
    int k;
    int rises = 0, nbit = 0, wcnt = 0, csfalls = 0, seen = 0;
    int v_setup = 0, v_gap = 0, v_mosi = 0;
    longint t_fall = 0, t_rise = -1000;

    if (g == 0) begin : g_sel0
      assign sck = bus0.spi_sck;
      assign cs_n = bus0.spi_cs_n;
      assign mosi = bus0.spi_mosi;
      assign wr = bus0.cfg_wr;
      assign wa = bus0.cfg_addr;
      assign wd = bus0.cfg_data;
      assign bus0.spi_miso = miso;
    end else begin : g_sel1
      assign sck = bus1.spi_sck;
      assign cs_n = bus1.spi_cs_n;
      assign mosi = bus1.spi_mosi;
      assign wr = bus1.cfg_wr;
      assign wa = bus1.cfg_addr;
      assign wd = bus1.cfg_data;
      assign bus1.spi_miso = miso;
    end

    always @(negedge cs_n) begin
      csfalls++;
      if (longint'($time) - t_rise < longint'(2 * SCK_DIV * PER)) v_gap++;
      t_fall = longint'($time);
    end

    always @(posedge cs_n) t_rise = longint'($time);

    always @(posedge sck) begin
      if (cs_n === 1'b0) begin
        if (seen != csfalls) begin
          seen = csfalls;
          nbit = 0;
          if (longint'($time) - t_fall < longint'(SCK_DIV * PER)) v_setup++;
        end
        rises++;
        if (nbit < 24) cmdcap = {cmdcap[22:0], mosi};
        nbit++;
        mosi_rise = mosi;
      end
    end

    always @(negedge sck) begin
      if (cs_n === 1'b0 && nbit >= 24) begin
        k = nbit - 24;
        a = cmdcap[8:0] + 9'(k / 8);
        miso = mem[g][a][3'(7 - (k % 8))];
      end
    end

    always @(negedge clk28) begin
      if (sck === 1'b1 && mosi !== mosi_rise) v_mosi++;
      if (wr === 1'b1) begin
        wlog[wcnt[5:0]] = {wa, wd};
        wcnt++;
      end
    end
  end

  function automatic int f_wcnt(input int g);
    return (g == 0) ? g_mon[0].wcnt : g_mon[1].wcnt;
  endfunction
  function automatic int f_rises(input int g);
    return (g == 0) ? g_mon[0].rises : g_mon[1].rises;
  endfunction
  function automatic int f_falls(input int g);
    return (g == 0) ? g_mon[0].csfalls : g_mon[1].csfalls;
  endfunction
  function automatic logic [23:0] f_cmd(input int g);
    return (g == 0) ? g_mon[0].cmdcap : g_mon[1].cmdcap;
  endfunction
  function automatic logic [15:0] f_wlog(input int g, input int idx);
    return (g == 0) ? g_mon[0].wlog[idx[5:0]] : g_mon[1].wlog[idx[5:0]];
  endfunction
  function automatic logic [4:0] f_stat(input int g);
    if (g == 0) return {bus0.busy, bus0.done, bus0.valid, bus0.spi_cs_n, bus0.cfg_wr};
    return {bus1.busy, bus1.done, bus1.valid, bus1.spi_cs_n, bus1.cfg_wr};
  endfunction
  function automatic int nregs(input int g);
    return (g == 0) ? 10 : 1;
  endfunction
  function automatic logic [15:0] eaddr(input int g);
    return (g == 0) ? 16'h0000 : 16'h0100;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int g, input string tag);
    logic [4:0] s;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk28);
      s = f_stat(g);
      if (s[4] == 1'b0 && s[3] == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_finished"}, 32'(ok), 32'd1);
  endtask

  // Expected behaviour: valid signature -> one write per stored byte, else none.
  task automatic check_xfer(input int g, input int wb, input int rb, input int fb, input string tag);
    logic [8:0] ea;
    logic [4:0] s;
    bit sig_ok;
    int n;
    ea = eaddr(g)[8:0];
    sig_ok = (mem[g][ea] == 8'h5A);
    n = sig_ok ? nregs(g) : 0;
    chk({tag, "_nwrites"}, f_wcnt(g) - wb, n);
    chk({tag, "_sck_rises"}, f_rises(g) - rb, 32 + 8 * n);
    chk({tag, "_cs_falls"}, f_falls(g) - fb, 1);
    chk({tag, "_command"}, 32'(f_cmd(g)), 32'({8'h03, eaddr(g)}));
    for (int i = 0; i < n; i++)
      chk({tag, "_write"}, 32'(f_wlog(g, wb + i)), 32'({8'(i), mem[g][ea + 9'(1 + i)]}));
    s = f_stat(g);
    chk({tag, "_status"}, 32'(s[4:1]), 32'({1'b0, 1'b1, sig_ok, 1'b1}));
  endtask

  task automatic rand_image(input int g, input bit ok);
    logic [8:0] ea;
    ea = eaddr(g)[8:0];
    for (int i = 0; i <= nregs(g); i++) mem[g][ea + 9'(i)] = 8'($urandom_range(0, 255));
    if (ok) mem[g][ea] = 8'h5A;
    else if (mem[g][ea] == 8'h5A) mem[g][ea] = 8'hA5;
  endtask

  task automatic pulse0();
    @(negedge clk28);
    bus0.start = 1'b1;
    @(negedge clk28);
    bus0.start = 1'b0;
  endtask

  task automatic run0(input string tag);
    int wb, rb, fb;
    wb = f_wcnt(0);
    rb = f_rises(0);
    fb = f_falls(0);
    pulse0();
    wait_done(0, tag);
    check_xfer(0, wb, rb, fb, tag);
  endtask

  initial begin
    logic [7:0] plan [0:10];
    int wb, rb, fb, wb1, rb1, fb1;
    bit ok;
    plan = '{8'h5A, 8'h01, 8'h00, 8'h02, 8'h01, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h01};
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 512; i++) mem[g][i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 11; i++) mem[0][i] = plan[i];
    rand_image(1, 1'b1);

    repeat (12) @(negedge clk28);
    chk("rst_sck", 32'(bus0.spi_sck), 32'd0);
    chk("rst_cs_n", 32'(bus0.spi_cs_n), 32'd1);
    chk("rst_mosi", 32'(bus0.spi_mosi), 32'd0);
    chk("rst_cfg_wr", 32'(bus0.cfg_wr), 32'd0);
    chk("rst_cfg_addr", 32'(bus0.cfg_addr), 32'd0);
    chk("rst_cfg_data", 32'(bus0.cfg_data), 32'd0);
    chk("rst_busy", 32'(bus0.busy), 32'd0);
    chk("rst_done", 32'(bus0.done), 32'd0);
    chk("rst_valid", 32'(bus0.valid), 32'd0);

    // Auto-start of both loaders on reset release.
    rst = 1'b0;
    wait_done(0, "auto0");
    check_xfer(0, 0, 0, 0, "auto0");
    wait_done(1, "auto1");
    check_xfer(1, 0, 0, 0, "auto1");

    mem[0][0] = 8'hA5;
    run0("abort");

    for (int t = 0; t < 4; t++) begin
      rand_image(0, t != 2);
      run0("rand");
    end

    // start pulsed while DATA bytes are flowing must not queue a second load.
    rand_image(0, 1'b1);
    wb = f_wcnt(0);
    rb = f_rises(0);
    fb = f_falls(0);
    pulse0();
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk28);
      if (f_wcnt(0) - wb >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    chk("busy_reach_data", 32'(ok), 32'd1);
    pulse0();
    wait_done(0, "busy_start");
    check_xfer(0, wb, rb, fb, "busy_start");
    repeat (40) @(negedge clk28);
    chk("busy_start_single", f_falls(0) - fb, 32'd1);
    chk("busy_start_idle", 32'(bus0.busy), 32'd0);

    run0("again");

    // Reset after the third data byte has been written.
    rand_image(0, 1'b1);
    wb = f_wcnt(0);
    pulse0();
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk28);
      if (f_wcnt(0) - wb >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_reach_byte3", 32'(ok), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cs_n", 32'(bus0.spi_cs_n), 32'd1);
    chk("mid_rst_cfg_wr", 32'(bus0.cfg_wr), 32'd0);
    chk("mid_rst_busy", 32'(bus0.busy), 32'd0);
    repeat (10) @(negedge clk28);
    chk("mid_rst_no_partial", f_wcnt(0) - wb, 32'd3);
    wb = f_wcnt(0);
    rb = f_rises(0);
    fb = f_falls(0);
    wb1 = f_wcnt(1);
    rb1 = f_rises(1);
    fb1 = f_falls(1);
    rst = 1'b0;
    wait_done(0, "reload0");
    check_xfer(0, wb, rb, fb, "reload0");
    wait_done(1, "reload1");
    check_xfer(1, wb1, rb1, fb1, "reload1");

    chk("cs_setup0", g_mon[0].v_setup, 32'd0);
    chk("cs_gap0", g_mon[0].v_gap, 32'd0);
    chk("mosi_stable0", g_mon[0].v_mosi, 32'd0);
    chk("cs_setup1", g_mon[1].v_setup, 32'd0);
    chk("cs_gap1", g_mon[1].v_gap, 32'd0);
    chk("mosi_stable1", g_mon[1].v_mosi, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

`default_nettype wire
